// File: rtl/hdmi_audio_sched.sv
// hdmi_audio_sched: Bresenham audio strobe generator with capture FIFO toward the HDMI packetizer.
module hdmi_audio_sched #(
    parameter int SAMPLE_RATE = 48000,
    parameter int CLK_W       = 27,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLDOFF     = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CLK_W-1:0] clk_hz,
    output logic             audio_sample,
    input  logic [31:0]      sample_in,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             locked,
    output logic [7:0]       overflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int HW = HOLDOFF > 1 ? $clog2(HOLDOFF) : 1;
    localparam logic [CLK_W-1:0] MIN_HZ    = CLK_W'(2 * SAMPLE_RATE);
    localparam logic [CLK_W:0]   RATE      = (CLK_W + 1)'(SAMPLE_RATE);
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLDOFF - 1);
    localparam logic [AW:0]      DEPTH     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;

    state_t           state_q, state_d;
    logic [CLK_W-1:0] clk_q, clk_d;
    logic [CLK_W:0]   acc_q, acc_d, sum;
    logic [HW-1:0]    hold_q, hold_d;
    logic             smp_q, smp_d, cap_q;
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [7:0]       ovf_q, ovf_d;
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic             bad_hz, run_stay, full, push, pop, wr_en;

    assign audio_sample = smp_q;
    assign locked       = state_q == RUN;
    assign overflow_cnt = ovf_q;
    assign out_valid    = wr_q != rd_q;
    assign out_data     = out_valid ? mem_q[rd_q[AW-1:0]] : '0;

    always_comb begin
        state_d = state_q;
        clk_d   = clk_q;
        hold_d  = hold_q;
        acc_d   = '0;
        smp_d   = 1'b0;
        bad_hz  = clk_hz < MIN_HZ;
        sum     = acc_q + RATE;
        if (state_q == IDLE) begin
            clk_d = clk_hz;
            if (enable && !bad_hz) begin
                state_d = HOLD;
                hold_d  = '0;
            end
        end else if (!enable) begin
            state_d = IDLE;
        end else if (clk_hz != clk_q || bad_hz) begin
            state_d = HOLD;
            clk_d   = clk_hz;
            hold_d  = '0;
        end else if (state_q == HOLD) begin
            if (hold_q == HOLD_LAST) state_d = RUN;
            else hold_d = hold_q + 1'b1;
        end else begin
            smp_d = sum >= {1'b0, clk_q};
            acc_d = smp_d ? sum - {1'b0, clk_q} : sum;
        end
        // Anything other than staying in RUN empties the FIFO and drops a pending capture.
        run_stay = state_q == RUN && state_d == RUN;
        full     = (wr_q - rd_q) == DEPTH;
        pop      = run_stay && out_valid && out_ready;
        push     = run_stay && cap_q;
        wr_en    = push && (!full || pop);
        wr_d     = run_stay ? wr_q + (AW + 1)'(wr_en) : '0;
        rd_d     = run_stay ? rd_q + (AW + 1)'(pop) : '0;
        ovf_d    = ovf_q + 8'(push && full && !pop && ovf_q != 8'hFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            clk_q   <= '0;
            acc_q   <= '0;
            hold_q  <= '0;
            smp_q   <= 1'b0;
            cap_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            ovf_q   <= '0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            acc_q   <= acc_d;
            hold_q  <= hold_d;
            smp_q   <= smp_d;
            cap_q   <= smp_q;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= sample_in;
    end
endmodule

// File: tb/tb_hdmi_audio_sched.sv
// tb_hdmi_audio_sched: scoreboard bench for strobe timing, FIFO capture/drain, overflow and restarts.
module tb_hdmi_audio_sched;
    logic        clk = 1'b0;
    logic        reset, enable, out_ready;
    logic [26:0] clk_hz;
    logic [31:0] sample_in, out_data;
    logic        audio_sample, out_valid, locked;
    logic [7:0]  overflow_cnt;

    int          n_checks = 0, n_errors = 0;
    logic [31:0] sb[$];
    logic [31:0] word = 32'h12345678, pend_word = '0;
    logic        strobe_prev = 1'b0, prev_as = 1'b0, flush_pend = 1'b0, pend_push = 1'b0;
    int          exp_ovf = 0, adj = 0, n = 0, bad = 0, cnt = 0;

    always #5 clk = ~clk;

    hdmi_audio_sched #(.HOLDOFF(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clk_hz(clk_hz),
        .audio_sample(audio_sample), .sample_in(sample_in), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .locked(locked),
        .overflow_cnt(overflow_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Handshake and pending capture are resolved before the edge, with this cycle's inputs final.
    task automatic cyc();
        if (sb.size() != 0 && out_ready) begin
            check("pop_data", out_data, sb[0]);
            void'(sb.pop_front());
        end
        if (pend_push) begin
            if (sb.size() < 4) sb.push_back(pend_word);
            else if (exp_ovf < 255) exp_ovf++;
            pend_push = 1'b0;
        end
        @(posedge clk);
        #1;
        if (flush_pend) begin
            sb.delete();
            strobe_prev = 1'b0;
            flush_pend  = 1'b0;
        end
        check("valid", 32'(out_valid), 32'(sb.size() != 0));
        check("ovf", 32'(overflow_cnt), 32'(exp_ovf));
        if (strobe_prev) begin
            sample_in = word;
            pend_word = word;
            pend_push = 1'b1;
            word      = word + 32'h01010101;
        end
        strobe_prev = audio_sample;
        if (audio_sample && prev_as) adj++;
        prev_as = audio_sample;
    endtask

    task automatic wait_strobe(output int k);
        k = 0;
        do begin
            cyc();
            k++;
        end while (!audio_sample && k < 200);
    endtask

    task automatic relock(input logic [26:0] hz);
        clk_hz     = hz;
        flush_pend = 1'b1;
        cyc();
        check("unlock", 32'(locked), 32'd0);
        check("flushed", 32'(out_valid), 32'd0);
        bad = int'(audio_sample);
        for (int i = 0; i < 15; i++) begin
            cyc();
            bad += int'(audio_sample) + int'(locked);
        end
        check("hold_quiet", 32'(bad), 32'd0);
        cyc();
        check("relocked", 32'(locked), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; out_ready = 1'b1;
        clk_hz = 27'd480000; sample_in = '0;
        repeat (3) cyc();
        check("rst_strobe", 32'(audio_sample), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_data", out_data, 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            bad += int'(audio_sample) + int'(locked) + int'(out_valid) + int'(overflow_cnt != 0);
        end
        check("idle_quiet", 32'(bad), 32'd0);
        enable = 1'b1;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            bad += int'(locked) + int'(audio_sample);
        end
        check("holdoff", 32'(bad), 32'd0);
        cyc();
        check("locked", 32'(locked), 32'd1);
        wait_strobe(n);
        check("first_gap", 32'(n), 32'd10);
        cyc();
        cyc();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_data", out_data, 32'h12345678);
        cyc();
        check("first_drained", 32'(out_valid), 32'd0);
        wait_strobe(n);
        check("gap480_a", 32'(n), 32'd7);
        for (int i = 0; i < 2; i++) begin
            wait_strobe(n);
            check("gap480", 32'(n), 32'd10);
        end
        repeat (3) cyc();
        out_ready = 1'b0;
        repeat (6) wait_strobe(n);
        cyc();
        cyc();
        check("ovf_two", 32'(overflow_cnt), 32'd2);
        check("full_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        repeat (4) cyc();
        check("drain_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        repeat (2) wait_strobe(n);
        cyc();
        cyc();
        check("two_queued", 32'(sb.size()), 32'd2);
        out_ready = 1'b1;
        relock(27'd240000);
        wait_strobe(n);
        check("first_gap240", 32'(n), 32'd5);
        for (int i = 0; i < 3; i++) begin
            wait_strobe(n);
            check("gap240", 32'(n), 32'd5);
        end
        relock(27'd100000);
        adj = 0;
        for (int w = 0; w < 3; w++) begin
            cnt = 0;
            for (int i = 0; i < 100; i++) begin
                cyc();
                cnt += int'(audio_sample);
            end
            check("strobes_per_100", 32'(cnt), 32'd48);
        end
        check("adjacent", 32'(adj), 32'd0);
        reset      = 1'b1;
        flush_pend = 1'b1;
        exp_ovf    = 0;
        cyc();
        check("mid_rst_strobe", 32'(audio_sample), 32'd0);
        check("mid_rst_locked", 32'(locked), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ovf", 32'(overflow_cnt), 32'd0);
        check("mid_rst_data", out_data, 32'd0);
        reset = 1'b0;
        repeat (3) cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
